// File: rtl/proc_pkg.sv
// Shared datapath widths, ALU opcodes and instruction-field positions for the
// 8-bit pipeline.
package proc_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SLL = 1'b1;

  localparam int RW_N_BIT  = 7;
  localparam int ALUOP_BIT = 6;
  localparam int RD_MSB    = 5;
  localparam int RD_LSB    = 3;
  localparam int RS_MSB    = 2;
  localparam int RS_LSB    = 0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU: modular add, or logical left shift of A by a small
// immediate shift amount (zero fill).
module ex_alu
  import proc_pkg::*;
#(
  parameter int W  = DATA_W,
  parameter int SW = REG_AW
) (
  input  logic          op_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic [SW-1:0] shamt_i,
  output logic [W-1:0]  result_o
);

  always_comb begin
    result_o = a_i + b_i;
    if (op_i == ALU_SLL) begin
      result_o = a_i << shamt_i;
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute / write-back back end: ID/EX and EX/WB registers, ALU, EX forwarding
// and retired-instruction counter. Define EX_FORWARDING_EN to enable forwarding.
module ex_wb_stage
  import proc_pkg::*;
#(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int REG_AW = proc_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_alu_op,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [DATA_W-1:0] id_read_data_1,
  input  logic [DATA_W-1:0] id_read_data_2,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic              idex_valid_q, idex_reg_write_q, idex_alu_op_q;
  logic [REG_AW-1:0] idex_rd_q, idex_rs_q;
  logic [DATA_W-1:0] idex_rd1_q, idex_rd2_q;

  logic              exwb_reg_write_q;
  logic [REG_AW-1:0] exwb_rd_q;
  logic [DATA_W-1:0] exwb_data_q;

  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [DATA_W-1:0] op_a, op_b, alu_result;

`ifdef EX_FORWARDING_EN
  // B only forwards for adds; for shifts the rs field is an immediate.
  always_comb begin
    op_a = idex_rd1_q;
    op_b = idex_rd2_q;
    if (exwb_reg_write_q && (exwb_rd_q == idex_rd_q)) begin
      op_a = exwb_data_q;
    end
    if (exwb_reg_write_q && (exwb_rd_q == idex_rs_q) && (idex_alu_op_q == ALU_ADD)) begin
      op_b = exwb_data_q;
    end
  end
`else
  assign op_a = idex_rd1_q;
  assign op_b = idex_rd2_q;
`endif

  ex_alu #(
    .W  (DATA_W),
    .SW (REG_AW)
  ) u_alu (
    .op_i     (idex_alu_op_q),
    .a_i      (op_a),
    .b_i      (op_b),
    .shamt_i  (idex_rs_q),
    .result_o (alu_result)
  );

  assign retire_d = exwb_reg_write_q ? retire_q + 1'b1 : retire_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_valid_q     <= 1'b0;
      idex_reg_write_q <= 1'b0;
      idex_alu_op_q    <= 1'b0;
      idex_rd_q        <= '0;
      idex_rs_q        <= '0;
      idex_rd1_q       <= '0;
      idex_rd2_q       <= '0;
      exwb_reg_write_q <= 1'b0;
      exwb_rd_q        <= '0;
      exwb_data_q      <= '0;
      retire_q         <= '0;
    end else begin
      // A flushed slot becomes a bubble that never writes or counts.
      idex_valid_q     <= id_valid & ~flush;
      idex_reg_write_q <= id_reg_write & id_valid & ~flush;
      idex_alu_op_q    <= id_alu_op;
      idex_rd_q        <= id_rd;
      idex_rs_q        <= id_rs;
      idex_rd1_q       <= id_read_data_1;
      idex_rd2_q       <= id_read_data_2;
      exwb_reg_write_q <= idex_reg_write_q & idex_valid_q;
      exwb_rd_q        <= idex_rd_q;
      exwb_data_q      <= alu_result;
      retire_q         <= retire_d;
    end
  end

  assign wb_reg_write  = exwb_reg_write_q;
  assign wb_write_reg  = exwb_rd_q;
  assign wb_write_data = exwb_data_q;
  assign retire_count  = retire_q;

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute and write-back back end of the 8-bit pipelined processor; sits directly downstream of the instruction-decode stage (register file plus control unit).
- Owns the ID/EX and EX/WB pipeline registers, the ALU and the EX-stage forwarding path.
- Drives the register-file write port (RegWrite, Write_Reg, Write_Data) from the EX/WB register.
- Keeps a retired-instruction counter.

Parameters:
- DATA_W, 8, datapath and register width.
- REG_AW, 3, register-number width (8 registers).
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  squash the instruction being captured into ID/EX (taken jump).
- id_valid  in  1  decode stage presents an instruction this cycle.
- id_reg_write  in  1  RegWrite from the control unit (~IR[7]).
- id_alu_op  in  1  AluOp from the control unit (IR[6]).
- id_rd  in  REG_AW  IR[5:3]; destination and first source.
- id_rs  in  REG_AW  IR[2:0]; second source register, or shift amount.
- id_read_data_1  in  DATA_W  register-file read of id_rd.
- id_read_data_2  in  DATA_W  register-file read of id_rs.
- wb_reg_write  out  1  register-file write enable.
- wb_write_reg  out  REG_AW  register-file write address.
- wb_write_data  out  DATA_W  register-file write data.
- retire_count  out  CNT_W  count of retired register-writing instructions.

Behaviour:
- Reset is asynchronous and active-low on reset. While reset=0:
  - All ID/EX and EX/WB fields clear: valid=0, reg_write=0, addresses=0, data=0.
  - wb_reg_write=0, wb_write_reg=0, wb_write_data=0, retire_count=0.
  - A reset asserted mid-operation discards in-flight instructions with no partial write.
- ID/EX capture, every posedge:
  - idex_valid <= id_valid & ~flush.
  - idex_reg_write <= id_reg_write & id_valid & ~flush.
  - All other fields are captured unconditionally.
  - A flushed slot is a bubble: it is never written and never counted.
- ALU, combinational from ID/EX:
  - Operand A = forwarded rd data. Operand B = forwarded rs data.
  - AluOp=0: result = (A + B) mod 2^DATA_W; carry is discarded.
  - AluOp=1: result = A << idex_rs, where idex_rs is the 0..7 shift amount; zero fill; bits shifted out are lost.
- Forwarding:
  - If exwb_reg_write=1 and exwb_rd == idex_rd, A = exwb_data; otherwise A = idex_read_data_1.
  - Same rule for B against idex_rs, applied only when AluOp=0.
  - Both operands may forward in the same cycle (e.g. rd == rs == exwb_rd).
  - Distance-2 hazards need no handling: the register file writes combinationally before the decode read.
- EX/WB capture, every posedge:
  - exwb_reg_write <= idex_reg_write. exwb_rd <= idex_rd. exwb_data <= ALU result.
  - Latency: an instruction presented at ID in cycle N appears on wb_* in cycle N+2.
- Outputs are driven directly from the EX/WB flops (no combinational path): wb_reg_write=exwb_reg_write, wb_write_reg=exwb_rd, wb_write_data=exwb_data.
- retire_count increments by 1 on each posedge where exwb_reg_write=1, and wraps from 2^CNT_W-1 to 0.
- Instructions with IR[7]=1 (RegWrite=0) travel as valid non-writing slots: no write, no forward, no count.

Optional Feature:
- Macro: EX_FORWARDING_EN.
- Defined: forwarding operates as specified above.
- Undefined:
  - The forwarding muxes are removed; A = idex_read_data_1 and B = idex_read_data_2 always.
  - Software must insert one non-writing instruction between dependent instructions.
  - All other behaviour, including latency and counter, is unchanged.

Decomposition:
- Shared package, proc_pkg:
  - DATA_W, REG_AW.
  - ALU_ADD=1'b0 and ALU_SLL=1'b1 constants.
  - Instruction bit-position constants: RW_N_BIT=7, ALUOP_BIT=6, RD_MSB/LSB=5/3, RS_MSB/LSB=2/0.
- One natural sub-module: ex_alu (combinational add/shift on op, a, b, shamt).
- Forwarding muxes and pipeline registers stay in ex_wb_stage.

Test Plan:
- Reset defaults: hold reset=0 mid-stream with an add in flight → all wb_* = 0 and retire_count=0 immediately; no write after release.
- Plain add: r1=1, r2=2; issue add rd=1, rs=2 → cycle N+2: wb_reg_write=1, wb_write_reg=1, wb_write_data=8'h03; retire_count=1.
- Back-to-back forward: issue add r1,r2 then add r1,r1 with stale reads of 1 → second result 8'h06 (3+3). With EX_FORWARDING_EN undefined → 8'h02.
- Shift with wrap: r5=8'h85; issue sll rd=5, shamt=1 → wb_write_data=8'h0A. Add r7=8'hFF + r1=1 → 8'h00, carry dropped.
- Flush and non-writing slot: an add presented with flush=1 and an IR[7]=1 instruction → wb_reg_write stays 0 for both, retire_count unchanged, and no forwarding occurs from either.
- Counter wrap: preload or run 65535 retirements, then one more add → retire_count = 0.
